// File: rtl/pipe_pkg.sv
// Shared pipeline payload definitions.
// Every stage that packs or unpacks a pipeline payload imports this package.
// Producer and consumer then agree on field order, offsets and per-stage widths.
// Contents: field widths, the EXE->MEM payload struct, its bit offsets, and stage payload widths.
package pipe_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned CSR_AW  = 14;
    localparam int unsigned ECODE_W = 6;
    localparam int unsigned OCC_W   = 2;

    // EXE->MEM payload; the first field declared is the most significant
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    alu_result;
        logic [REG_AW-1:0]  rd;
        logic               rf_we;
        logic               res_from_mem;
        logic [CSR_AW-1:0]  csr_num;
        logic               csr_we;
        logic               ex;
        logic [ECODE_W-1:0] ecode;
        logic               is_ertn;
    } exe_mem_t;

    // LSB offsets of each field inside the flattened exe_mem_t vector
    localparam int unsigned EM_ERTN_LSB  = 0;
    localparam int unsigned EM_ECODE_LSB = EM_ERTN_LSB + 1;
    localparam int unsigned EM_EX_LSB    = EM_ECODE_LSB + ECODE_W;
    localparam int unsigned EM_CSRWE_LSB = EM_EX_LSB + 1;
    localparam int unsigned EM_CSR_LSB   = EM_CSRWE_LSB + 1;
    localparam int unsigned EM_MEM_LSB   = EM_CSR_LSB + CSR_AW;
    localparam int unsigned EM_RFWE_LSB  = EM_MEM_LSB + 1;
    localparam int unsigned EM_RD_LSB    = EM_RFWE_LSB + 1;
    localparam int unsigned EM_ALU_LSB   = EM_RD_LSB + REG_AW;
    localparam int unsigned EM_PC_LSB    = EM_ALU_LSB + XLEN;

    // Payload widths per pipeline boundary
    localparam int unsigned IF_ID_W   = 2 * XLEN;
    localparam int unsigned ID_EXE_W  = 160;
    localparam int unsigned EXE_MEM_W = $bits(exe_mem_t);
    localparam int unsigned MEM_WB_W  = 2 * XLEN + REG_AW + 1;

endpackage

// File: rtl/pipe_entry.sv
// One pipeline storage entry: a payload register plus its valid bit.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   kill_i            flush: clear valid; payload is zeroed if CLEAR_PAYLOAD
//   load_i            capture data_i and set valid
//   drop_i            clear valid only; payload holds its value
//   data_i            payload in
//   valid_o, data_o   registered entry state
// Priority: rst > kill_i > load_i > drop_i > hold.
module pipe_entry #(
    parameter int unsigned DATA_W        = 32,
    parameter bit          CLEAR_PAYLOAD = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              kill_i,
    input  logic              load_i,
    input  logic              drop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q,  data_d;

    // Next-state logic. An X on an enable falls through to hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (kill_i) begin
            valid_d = 1'b0;
            if (CLEAR_PAYLOAD) data_d = '0;
        end else if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (drop_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= CLEAR_PAYLOAD ? '0 : data_q;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage register.
// It has an optional skid entry, a flush input and a saturating stall counter.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   flush                drop every held entry and the payload offered this cycle
//   in_valid/in_ready    upstream handshake
//   in_data              upstream payload
//   out_valid/out_ready  downstream handshake
//   out_data             oldest held payload
//   occupancy            number of held entries
//   stall_cnt            saturating count of cycles with out_valid & ~out_ready
// SKID=1 adds a second entry, so in_ready depends only on registered state.
// SKID=0 uses a single entry; in_ready then passes out_ready through combinationally.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W        = 32,
    parameter bit          SKID          = 1'b1,
    parameter bit          CLEAR_PAYLOAD = 1'b1,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              main_v;
    logic [DATA_W-1:0] main_data;
    logic [DATA_W-1:0] main_din;
    logic              main_load;
    logic              main_drop;
    logic              accept;
    logic              pop;
    logic [CNT_W-1:0]  stall_q, stall_d;

    assign accept = in_valid & in_ready;
    assign pop    = main_v & out_ready;

    generate
        if (SKID) begin : g_skid
            logic              skid_v;
            logic [DATA_W-1:0] skid_data;
            logic              skid_load;
            logic              skid_drop;

            assign in_ready = ~skid_v;

            // While skid is full, in_ready is low, so the refill from skid never meets an accept
            assign main_load = (accept & (~main_v | pop)) | (pop & skid_v);
            assign main_drop = pop & ~skid_v & ~accept;
            assign main_din  = skid_v ? skid_data : in_data;
            assign skid_load = accept & main_v & ~pop;
            assign skid_drop = pop & skid_v;

            // skid_v implies main_v, so the count is a direct decode
            assign occupancy = {skid_v, main_v & ~skid_v};

            pipe_entry #(
                .DATA_W        (DATA_W),
                .CLEAR_PAYLOAD (CLEAR_PAYLOAD)
            ) u_skid (
                .clk     (clk),
                .rst     (rst),
                .kill_i  (flush),
                .load_i  (skid_load),
                .drop_i  (skid_drop),
                .data_i  (in_data),
                .valid_o (skid_v),
                .data_o  (skid_data)
            );
        end else begin : g_single
            assign in_ready  = ~main_v | out_ready;
            assign main_load = accept;
            assign main_drop = pop & ~accept;
            assign main_din  = in_data;
            assign occupancy = {1'b0, main_v};
        end
    endgenerate

    pipe_entry #(
        .DATA_W        (DATA_W),
        .CLEAR_PAYLOAD (CLEAR_PAYLOAD)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .kill_i  (flush),
        .load_i  (main_load),
        .drop_i  (main_drop),
        .data_i  (main_din),
        .valid_o (main_v),
        .data_o  (main_data)
    );

    // Stall counter: counts through a flush, is cleared only by reset, and saturates at all ones
    always_comb begin
        stall_d = stall_q;
        if (main_v && !out_ready && (stall_q != {CNT_W{1'b1}}))
            stall_d = stall_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end

    assign out_valid = main_v;
    assign out_data  = main_data;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid.
// Instances under test:
//   A: DATA_W=32,  SKID=1, CLEAR_PAYLOAD=1, CNT_W=16   directed table + random
//   B: DATA_W=160, SKID=0, CLEAR_PAYLOAD=0, CNT_W=4    saturation + random
//   C: DATA_W=1,   SKID=1, CLEAR_PAYLOAD=1, CNT_W=8    random
module tb_pipe_stage_skid;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic         a_flush, a_iv, a_ir, a_ov, a_or;
    logic [31:0]  a_din, a_dout;
    logic [1:0]   a_occ;
    logic [15:0]  a_st;

    logic         b_flush, b_iv, b_ir, b_ov, b_or;
    logic [159:0] b_din, b_dout;
    logic [1:0]   b_occ;
    logic [3:0]   b_st;

    logic         c_flush, c_iv, c_ir, c_ov, c_or;
    logic [0:0]   c_din, c_dout;
    logic [1:0]   c_occ;
    logic [7:0]   c_st;

    pipe_stage_skid #(.DATA_W(32), .SKID(1'b1), .CLEAR_PAYLOAD(1'b1), .CNT_W(16)) u_a (
        .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_din), .out_valid(a_ov), .out_ready(a_or), .out_data(a_dout),
        .occupancy(a_occ), .stall_cnt(a_st));

    pipe_stage_skid #(.DATA_W(160), .SKID(1'b0), .CLEAR_PAYLOAD(1'b0), .CNT_W(4)) u_b (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_din), .out_valid(b_ov), .out_ready(b_or), .out_data(b_dout),
        .occupancy(b_occ), .stall_cnt(b_st));

    pipe_stage_skid #(.DATA_W(1), .SKID(1'b1), .CLEAR_PAYLOAD(1'b1), .CNT_W(8)) u_c (
        .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_iv), .in_ready(c_ir),
        .in_data(c_din), .out_valid(c_ov), .out_ready(c_or), .out_data(c_dout),
        .occupancy(c_occ), .stall_cnt(c_st));

    int checks = 0;
    int errors = 0;

    // Inputs applied before an edge, and the state expected just after that edge
    typedef struct {
        logic        rst;
        logic        flush;
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        ev;
        logic [31:0] ed;
        logic        cd;
        logic        eir;
        logic [1:0]  eocc;
        logic [15:0] est;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f, input logic iv, input logic [31:0] din,
                                input logic o, input logic ev, input logic [31:0] ed, input logic cd,
                                input logic eir, input logic [1:0] eocc, input logic [15:0] est);
        vec_t v;
        v.rst = r; v.flush = f; v.iv = iv; v.din = din; v.ordy = o;
        v.ev = ev; v.ed = ed; v.cd = cd; v.eir = eir; v.eocc = eocc; v.est = est;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // in_valid / out_ready must never be X once reset has been released
    always @(negedge clk)
        if (!rst)
            assert (!$isunknown({a_iv, a_or, b_iv, b_or, c_iv, c_or}))
            else $error("FAIL x_protocol in_valid/out_ready unknown");

    initial begin
        vec_t         tbl[$];
        logic [31:0]  qa[$];
        logic [159:0] qb[$];
        logic         qc[$];
        logic [159:0] pat;
        bit           drain;

        rst = 1'b1;
        a_flush = 1'b0; a_iv = 1'b0; a_din = '0; a_or = 1'b1;
        b_flush = 1'b0; b_iv = 1'b0; b_din = '0; b_or = 1'b1;
        c_flush = 1'b0; c_iv = 1'b0; c_din = '0; c_or = 1'b1;

        // Reset held 2 cycles with in_valid high
        tbl.push_back(mk(1, 0, 1, 32'hDEAD, 1, 0, 32'h0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 1, 32'hDEAD, 1, 0, 32'h0, 1, 1, 0, 0));
        // Streaming 1..8: each value appears one cycle after it is offered
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(0, 0, 1, 32'(k), 1, 1, 32'(k), 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1, 0, 0));
        // Backpressure: A to main, B to skid, C refused, then drain A then B
        tbl.push_back(mk(0, 0, 1, 32'hA, 0, 1, 32'hA, 1, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 32'hB, 0, 1, 32'hA, 1, 0, 2, 1));
        tbl.push_back(mk(0, 0, 1, 32'hC, 0, 1, 32'hA, 1, 0, 2, 2));
        tbl.push_back(mk(0, 0, 0, 32'h0, 0, 1, 32'hA, 1, 0, 2, 3));
        tbl.push_back(mk(0, 0, 0, 32'h0, 1, 1, 32'hB, 1, 1, 1, 3));
        tbl.push_back(mk(0, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1, 0, 3));
        // Flush with two entries held, then flush while the offered beat would be accepted
        tbl.push_back(mk(0, 0, 1, 32'hD, 0, 1, 32'hD, 1, 1, 1, 3));
        tbl.push_back(mk(0, 0, 1, 32'hE, 0, 1, 32'hD, 1, 0, 2, 4));
        tbl.push_back(mk(0, 1, 1, 32'hC0, 1, 0, 32'h0, 1, 1, 0, 4));
        tbl.push_back(mk(0, 0, 1, 32'hF, 0, 1, 32'hF, 1, 1, 1, 4));
        tbl.push_back(mk(0, 1, 1, 32'h60, 1, 0, 32'h0, 1, 1, 0, 4));
        tbl.push_back(mk(0, 0, 0, 32'h0, 1, 0, 32'h0, 1, 1, 0, 4));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; a_flush = tbl[i].flush; a_iv = tbl[i].iv;
            a_din = tbl[i].din; a_or = tbl[i].ordy;
            @(posedge clk); #1;
            chk($sformatf("vec%0d_out_valid", i), a_ov, tbl[i].ev);
            chk($sformatf("vec%0d_in_ready", i), a_ir, tbl[i].eir);
            chk($sformatf("vec%0d_occupancy", i), a_occ, tbl[i].eocc);
            chk($sformatf("vec%0d_stall_cnt", i), a_st, tbl[i].est);
            if (tbl[i].cd) chk($sformatf("vec%0d_out_data", i), a_dout, tbl[i].ed);
        end

        // B and C sat idle after reset
        chk("b_idle_out_valid", b_ov, 0);
        chk("b_idle_occupancy", b_occ, 0);
        chk("b_idle_stall_cnt", b_st, 0);
        chk("b_idle_in_ready", b_ir, 1);
        chk("c_idle_out_valid", c_ov, 0);
        chk("c_idle_stall_cnt", c_st, 0);
        chk("c_idle_in_ready", c_ir, 1);

        // B: saturation of the 4-bit counter, comb in_ready, flush keeps payload
        pat = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()} | 160'h1;
        b_iv = 1'b1; b_din = pat; b_or = 1'b0;
        @(posedge clk); #1;
        b_iv = 1'b0; b_din = '0;
        chk("sat_load_out_valid", b_ov, 1);
        chk("sat_load_out_data", b_dout, pat);
        chk("sat_load_stall_cnt", b_st, 0);
        chk("sat_in_ready_blocked", b_ir, 0);
        b_or = 1'b1; #1;
        chk("sat_in_ready_comb", b_ir, 1);
        b_or = 1'b0; #1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i == 9) chk("sat_stall_cnt_10", b_st, 10);
        end
        chk("sat_stall_cnt_15", b_st, 15);
        chk("sat_hold_out_data", b_dout, pat);
        b_flush = 1'b1;
        @(posedge clk); #1;
        b_flush = 1'b0; b_or = 1'b1;
        chk("b_flush_out_valid", b_ov, 0);
        chk("b_flush_occupancy", b_occ, 0);
        chk("b_flush_keeps_payload", b_dout, pat);
        chk("b_flush_stall_cnt", b_st, 15);

        // Random traffic on all three instances against per-instance scoreboards
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            drain = (n >= 3980);
            a_iv = !drain && ($urandom_range(0, 3) != 0);
            b_iv = !drain && ($urandom_range(0, 3) != 0);
            c_iv = !drain && ($urandom_range(0, 3) != 0);
            a_or = drain || ($urandom_range(0, 2) != 0);
            b_or = drain || ($urandom_range(0, 2) != 0);
            c_or = drain || ($urandom_range(0, 2) != 0);
            a_flush = !drain && ($urandom_range(0, 40) == 0);
            b_flush = !drain && ($urandom_range(0, 40) == 0);
            c_flush = !drain && ($urandom_range(0, 40) == 0);
            a_din = $urandom();
            b_din = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
            c_din = 1'($urandom());
            @(negedge clk);

            chk("rnd_a_occupancy", a_occ, 160'(qa.size()));
            chk("rnd_a_out_valid", a_ov, qa.size() != 0);
            if (a_ov && a_or && qa.size() != 0) begin
                chk("rnd_a_out_data", a_dout, qa[0]);
                void'(qa.pop_front());
            end
            if (a_flush) qa.delete();
            else if (a_iv && a_ir) qa.push_back(a_din);

            chk("rnd_b_occupancy", b_occ, 160'(qb.size()));
            chk("rnd_b_out_valid", b_ov, qb.size() != 0);
            if (b_ov && b_or && qb.size() != 0) begin
                chk("rnd_b_out_data", b_dout, qb[0]);
                void'(qb.pop_front());
            end
            if (b_flush) qb.delete();
            else if (b_iv && b_ir) qb.push_back(b_din);

            chk("rnd_c_occupancy", c_occ, 160'(qc.size()));
            chk("rnd_c_out_valid", c_ov, qc.size() != 0);
            if (c_ov && c_or && qc.size() != 0) begin
                chk("rnd_c_out_data", c_dout, qc[0]);
                void'(qc.pop_front());
            end
            if (c_flush) qc.delete();
            else if (c_iv && c_ir) qc.push_back(c_din[0]);

            @(posedge clk); #1;
        end
        chk("drain_a_empty", a_occ, 0);
        chk("drain_b_empty", b_occ, 0);
        chk("drain_c_empty", c_occ, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
